// File: rtl/estu_soc.sv
// Boot streamer: reads BOOT_LEN bytes from SPI flash at FLASH_BASE and sends them out on an 8N1 UART.
// Optional macro SOC_RX_ECHO_EN adds a UART receiver whose bytes are echoed on o_txd once booting is done.
module estu_soc #(
  parameter int unsigned CLK_FREQ_HZ = 12000000,
  parameter int unsigned BAUD_RATE   = 3000000,
  parameter logic [23:0] FLASH_BASE  = 24'h100000,
  parameter int unsigned BOOT_LEN    = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rxd,
  input  logic [2:0] buttons,
  output logic [3:0] led,
  output logic       o_txd,
  input  logic       i_flash_miso,
  output logic       o_flash_sck,
  output logic       o_flash_ss,
  output logic       o_flash_mosi
);

  localparam int unsigned DIV      = CLK_FREQ_HZ / BAUD_RATE;
  localparam logic [15:0] DIV_LAST = 16'(DIV - 1);
  localparam logic [15:0] LEN      = 16'(BOOT_LEN);
  localparam logic [31:0] CMD_WORD = {8'h03, FLASH_BASE};

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_READ, S_TX, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  bit_q, bit_d;
  logic        sck_q, sck_d;
  logic        ss_q, ss_d;
  logic        mosi_q, mosi_d;
  logic        txd_q, txd_d;
  logic [1:0]  led_hi_q, led_hi_d;
  logic [1:0]  led_lo_q, led_lo_d;
  logic [31:0] cmd_sr_q, cmd_sr_d;
  logic [7:0]  rd_sr_q, rd_sr_d;
  logic [7:0]  byte_q, byte_d;
  logic [8:0]  frame_q, frame_d;
  logic [15:0] baud_q, baud_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] cnt_inc;
  logic [1:0]  btn_s1_q, btn_s2_q;
  logic        btn0_prev_q;
  logic        btn0_rise;
  logic        start_cmd;

`ifdef SOC_RX_ECHO_EN
  localparam logic [15:0] HALF_LAST = 16'(DIV / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t   rx_state_q, rx_state_d;
  logic        rx_s1_q, rx_s2_q;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_sr_q, rx_sr_d;
  logic        rx_done;
  logic [7:0]  pend_q, pend_d;
  logic        pend_valid_q, pend_valid_d;
  logic        echo_busy_q, echo_busy_d;
  logic        unused_btn;
  assign unused_btn = buttons[2];
`else
  logic        unused_in;
  assign unused_in = buttons[2] ^ i_rxd;
`endif

  assign btn0_rise = btn_s2_q[0] & ~btn0_prev_q;

  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    sck_d     = sck_q;
    ss_d      = ss_q;
    mosi_d    = mosi_q;
    txd_d     = txd_q;
    led_hi_d  = led_hi_q;
    cmd_sr_d  = cmd_sr_q;
    rd_sr_d   = rd_sr_q;
    byte_d    = byte_q;
    frame_d   = frame_q;
    baud_d    = baud_q;
    cnt_d     = cnt_q;
    cnt_inc   = cnt_q + 16'd1;
    start_cmd = 1'b0;
`ifdef SOC_RX_ECHO_EN
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q;
    rx_bit_d     = rx_bit_q;
    rx_sr_d      = rx_sr_q;
    rx_done      = 1'b0;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    echo_busy_d  = echo_busy_q;

    case (rx_state_q)
      RX_IDLE: if (!rx_s2_q) begin
        rx_state_d = RX_START;
        rx_cnt_d   = '0;
      end
      RX_START: if (rx_cnt_q == HALF_LAST) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
      end else rx_cnt_d = rx_cnt_q + 16'd1;
      RX_DATA: if (rx_cnt_q == DIV_LAST) begin
        rx_cnt_d = '0;
        rx_sr_d  = {rx_s2_q, rx_sr_q[7:1]};
        rx_bit_d = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
      end else rx_cnt_d = rx_cnt_q + 16'd1;
      RX_STOP: if (rx_cnt_q == DIV_LAST) begin
        rx_state_d = RX_IDLE;
        rx_done    = rx_s2_q;
      end else rx_cnt_d = rx_cnt_q + 16'd1;
      default: rx_state_d = RX_IDLE;
    endcase
`endif

    case (state_q)
      S_IDLE: start_cmd = 1'b1;
      S_CMD: begin
        sck_d = ~sck_q;
        // MOSI only advances on the edge that drops SCK
        if (sck_q) begin
          if (bit_q == 5'd31) begin
            state_d = S_READ;
            bit_d   = '0;
            mosi_d  = 1'b0;
          end else begin
            bit_d    = bit_q + 5'd1;
            mosi_d   = cmd_sr_q[30];
            cmd_sr_d = {cmd_sr_q[30:0], 1'b0};
          end
        end
      end
      S_READ: begin
        sck_d = ~sck_q;
        if (sck_q) begin
          rd_sr_d = {rd_sr_q[6:0], i_flash_miso};
          if (bit_q == 5'd7) begin
            state_d = S_TX;
            byte_d  = {rd_sr_q[6:0], i_flash_miso};
            frame_d = {1'b1, rd_sr_q[6:0], i_flash_miso};
            txd_d   = 1'b0;
            bit_d   = '0;
            baud_d  = '0;
          end else begin
            bit_d = bit_q + 5'd1;
          end
        end
      end
      S_TX: begin
        if (baud_q != DIV_LAST) begin
          baud_d = baud_q + 16'd1;
        end else if (bit_q == 5'd9) begin
          // Stop bit complete; buttons[1] parks the stream here with the line idle
          led_hi_d = byte_q[1:0];
          if (!btn_s2_q[1]) begin
            cnt_d = cnt_inc;
            bit_d = '0;
            if (cnt_inc < LEN) begin
              state_d = S_READ;
            end else begin
              state_d = S_DONE;
              ss_d    = 1'b1;
            end
          end
        end else begin
          baud_d  = '0;
          bit_d   = bit_q + 5'd1;
          txd_d   = frame_q[0];
          frame_d = {1'b1, frame_q[8:1]};
        end
      end
      S_DONE: begin
`ifdef SOC_RX_ECHO_EN
        if (echo_busy_q) begin
          if (baud_q != DIV_LAST) begin
            baud_d = baud_q + 16'd1;
          end else if (bit_q == 5'd9) begin
            echo_busy_d = 1'b0;
            led_hi_d    = byte_q[1:0];
          end else begin
            baud_d  = '0;
            bit_d   = bit_q + 5'd1;
            txd_d   = frame_q[0];
            frame_d = {1'b1, frame_q[8:1]};
          end
        end else if (pend_valid_q) begin
          byte_d       = pend_q;
          frame_d      = {1'b1, pend_q};
          txd_d        = 1'b0;
          bit_d        = '0;
          baud_d       = '0;
          echo_busy_d  = 1'b1;
          pend_valid_d = 1'b0;
        end
        if (rx_done) begin
          pend_d       = rx_sr_q;
          pend_valid_d = 1'b1;
        end
`endif
        if (btn0_rise) start_cmd = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (start_cmd) begin
      state_d  = S_CMD;
      ss_d     = 1'b0;
      sck_d    = 1'b0;
      bit_d    = '0;
      cmd_sr_d = CMD_WORD;
      mosi_d   = CMD_WORD[31];
      cnt_d    = '0;
      txd_d    = 1'b1;
`ifdef SOC_RX_ECHO_EN
      echo_busy_d  = 1'b0;
      pend_valid_d = 1'b0;
`endif
    end

    led_lo_d = {state_d == S_DONE,
                (state_d == S_CMD) || (state_d == S_READ) || (state_d == S_TX)};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      bit_q       <= '0;
      sck_q       <= 1'b0;
      ss_q        <= 1'b1;
      mosi_q      <= 1'b0;
      txd_q       <= 1'b1;
      led_hi_q    <= '0;
      led_lo_q    <= '0;
      cmd_sr_q    <= '0;
      rd_sr_q     <= '0;
      byte_q      <= '0;
      frame_q     <= '0;
      baud_q      <= '0;
      cnt_q       <= '0;
      btn_s1_q    <= '0;
      btn_s2_q    <= '0;
      btn0_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_q       <= bit_d;
      sck_q       <= sck_d;
      ss_q        <= ss_d;
      mosi_q      <= mosi_d;
      txd_q       <= txd_d;
      led_hi_q    <= led_hi_d;
      led_lo_q    <= led_lo_d;
      cmd_sr_q    <= cmd_sr_d;
      rd_sr_q     <= rd_sr_d;
      byte_q      <= byte_d;
      frame_q     <= frame_d;
      baud_q      <= baud_d;
      cnt_q       <= cnt_d;
      btn_s1_q    <= buttons[1:0];
      btn_s2_q    <= btn_s1_q;
      btn0_prev_q <= btn_s2_q[0];
    end
  end

`ifdef SOC_RX_ECHO_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_state_q   <= RX_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_sr_q      <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      echo_busy_q  <= 1'b0;
    end else begin
      rx_s1_q      <= i_rxd;
      rx_s2_q      <= rx_s1_q;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_sr_q      <= rx_sr_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      echo_busy_q  <= echo_busy_d;
    end
  end
`endif

  assign led          = {led_hi_q, led_lo_q};
  assign o_txd        = txd_q;
  assign o_flash_sck  = sck_q;
  assign o_flash_ss   = ss_q;
  assign o_flash_mosi = mosi_q;

endmodule

// File: tb/tb_estu_soc.sv
// Scoreboard bench for estu_soc: SPI flash model and UART decoder pop expected commands/bytes from queues.
`timescale 1ns/1ps
module tb_estu_soc;
  localparam int unsigned CLK_HZ = 12000000;
  localparam int unsigned BAUD   = 3000000;
  localparam int unsigned DIV    = CLK_HZ / BAUD;
  localparam int unsigned BOUND  = 3000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic       miso = 1'b0;
  logic [2:0] buttons = '0;
  logic [3:0] led;
  logic       txd, sck, ss, mosi;

  estu_soc #(
    .CLK_FREQ_HZ(CLK_HZ),
    .BAUD_RATE  (BAUD),
    .FLASH_BASE (24'h100000),
    .BOOT_LEN   (2)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_rxd       (rxd),
    .buttons     (buttons),
    .led         (led),
    .o_txd       (txd),
    .i_flash_miso(miso),
    .o_flash_sck (sck),
    .o_flash_ss  (ss),
    .o_flash_mosi(mosi)
  );

  always #5 clk = ~clk;

  int unsigned tests = 0;
  int unsigned fails = 0;
  logic [31:0] exp_cmd[$];
  logic [7:0]  exp_byte[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // SPI flash model (mode 0): command captured on SCK rise, data driven on SCK fall
  int unsigned fbits = 0, dbit = 0, sck_rises = 0;
  logic [31:0] fcmd = '0;

  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    case (a)
      24'h100000: return 8'hA5;
      24'h100001: return 8'h3C;
      default:    return 8'hFF;
    endcase
  endfunction

  always @(posedge sck) begin
    sck_rises++;
    if (ss === 1'b0 && fbits < 32) begin
      fcmd = {fcmd[30:0], mosi};
      fbits++;
      if (fbits == 32) begin
        if (exp_cmd.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL flash_cmd_unexpected: got %h expected none", fcmd);
        end else begin
          chk("flash_cmd", fcmd, exp_cmd.pop_front());
        end
      end
    end
  end

  always @(negedge sck) begin
    logic [7:0] b;
    if (ss === 1'b0 && fbits >= 32) begin
      b = flash_byte(fcmd[23:0] + 24'(dbit / 8));
      miso = b[7 - (dbit % 8)];
      dbit++;
    end
  end

  always @(posedge ss) begin
    fbits = 0;
    dbit  = 0;
  end

  // UART decoder; frames overlapped by reset are discarded
  int unsigned started = 0, done_frames = 0, txd_lows = 0;

  always @(posedge clk) if (txd === 1'b0) txd_lows++;

  initial begin : uart_mon
    logic [7:0] d;
    logic ab, stp;
    d = '0;
    forever begin
      @(negedge txd);
      started++;
      repeat (DIV / 2) @(posedge clk);
      #1;
      ab = rst;
      if (txd === 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(posedge clk);
          #1;
          d[i] = txd;
          ab = ab | rst;
        end
        repeat (DIV) @(posedge clk);
        #1;
        stp = txd;
        ab = ab | rst;
        if (!ab) begin
          chk("uart_stop", {31'b0, stp}, 32'd1);
          if (exp_byte.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL uart_unexpected: got %h expected none", d);
          end else begin
            chk("uart_byte", {24'b0, d}, {24'b0, exp_byte.pop_front()});
          end
          done_frames++;
        end
      end
    end
  end

  task automatic cycles(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_boot();
    exp_cmd.push_back(32'h03100000);
    exp_byte.push_back(8'hA5);
    exp_byte.push_back(8'h3C);
  endtask

  task automatic wait_done_led(input logic v, input string name);
    int unsigned n = 0;
    while (led[1] !== v && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    chk(name, {31'b0, led[1]}, {31'b0, v});
  endtask

  task automatic pulse_btn0();
    buttons[0] = 1'b1;
    cycles(4);
    buttons[0] = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b);
    rxd = 1'b0;
    cycles(DIV);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      cycles(DIV);
    end
    rxd = 1'b1;
    cycles(DIV);
  endtask

  initial begin
    int unsigned base_d, base_s, r0, l0, n;

    @(posedge clk);
    @(negedge clk);
    chk("rst_txd",  {31'b0, txd},  32'd1);
    chk("rst_ss",   {31'b0, ss},   32'd1);
    chk("rst_sck",  {31'b0, sck},  32'd0);
    chk("rst_mosi", {31'b0, mosi}, 32'd0);
    chk("rst_led",  {28'b0, led},  32'd0);
    cycles(9);

    // First boot
    push_boot();
    rst = 1'b0;
    wait_done_led(1'b1, "boot1_done");
    chk("boot1_led",   {28'b0, led}, 32'h2);
    chk("boot1_ss",    {31'b0, ss},  32'd1);
    chk("boot1_bytes", done_frames,  32'd2);

    // Restart from DONE
    base_d = done_frames;
    push_boot();
    pulse_btn0();
    wait_done_led(1'b0, "restart_left_done");
    wait_done_led(1'b1, "restart_done");
    chk("restart_bytes", done_frames - base_d, 32'd2);
    chk("restart_led",   {28'b0, led}, 32'h2);

    // buttons[0] during READ is ignored
    base_d = done_frames;
    push_boot();
    pulse_btn0();
    n = 0;
    while (fbits < 32 && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    chk("read_reached", fbits, 32'd32);
    pulse_btn0();
    wait_done_led(1'b1, "read_btn_done");
    chk("read_btn_bytes", done_frames - base_d, 32'd2);

    // buttons[1] hold after first byte
    base_d = done_frames;
    base_s = started;
    push_boot();
    pulse_btn0();
    n = 0;
    while (started < base_s + 1 && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    chk("hold_first_start", started - base_s, 32'd1);
    buttons[1] = 1'b1;
    n = 0;
    while (done_frames < base_d + 1 && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    cycles(6);
    r0 = sck_rises;
    l0 = txd_lows;
    cycles(200);
    chk("hold_sck_edges", sck_rises - r0, 32'd0);
    chk("hold_txd_low",   txd_lows - l0,  32'd0);
    chk("hold_led",       {28'b0, led},   32'h5);
    chk("hold_bytes",     done_frames - base_d, 32'd1);
    buttons[1] = 1'b0;
    wait_done_led(1'b1, "hold_done");
    chk("hold_release_bytes", done_frames - base_d, 32'd2);

    // Reset during second byte
    base_s = started;
    push_boot();
    pulse_btn0();
    n = 0;
    while (started < base_s + 2 && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_second_start", started - base_s, 32'd2);
    cycles(6);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_ss",  {31'b0, ss},  32'd1);
    chk("rst_mid_txd", {31'b0, txd}, 32'd1);
    chk("rst_mid_sck", {31'b0, sck}, 32'd0);
    chk("rst_mid_led", {28'b0, led}, 32'h0);
    chk("rst_mid_pending", 32'(exp_byte.size()), 32'd1);
    exp_byte.delete();
    exp_cmd.delete();
    push_boot();
    cycles(9);
    base_d = done_frames;
    rst = 1'b0;
    wait_done_led(1'b1, "reboot_done");
    chk("reboot_bytes", done_frames - base_d, 32'd2);
    chk("reboot_led",   {28'b0, led}, 32'h2);

    // Receive path in DONE
    base_d = done_frames;
    l0 = txd_lows;
`ifdef SOC_RX_ECHO_EN
    exp_byte.push_back(8'h5A);
`endif
    send_rx(8'h5A);
    cycles(120);
`ifdef SOC_RX_ECHO_EN
    chk("echo_bytes", done_frames - base_d, 32'd1);
    chk("echo_led",   {30'b0, led[3:2]}, 32'd2);
`else
    chk("noecho_txd_low", txd_lows - l0, 32'd0);
    chk("noecho_led",     {28'b0, led},  32'h2);
`endif

    cycles(5);
    chk("cmd_queue_empty",  32'(exp_cmd.size()),  32'd0);
    chk("byte_queue_empty", 32'(exp_byte.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
